wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the writeback data width.
REQ-002 The block SHALL have port clk, input, 1 bit: the clock.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port req_valid, input, 3 bits: per-requester writeback valid (0=ALU, 1=LSU, 2=MDU).
REQ-005 The block SHALL have port req_rd, input, 15 bits: per-requester 5-bit destination index, requester i at [5i+4:5i].
REQ-006 The block SHALL have port req_data, input, 3*DATA_W bits: per-requester write data, requester i at [DATA_W*i +: DATA_W].
REQ-007 The block SHALL have port req_ready, output, 3 bits: per-requester accept, combinational.
REQ-008 The block SHALL have port wr_en, output, 1 bit: register-file write enable.
REQ-009 The block SHALL have port rd, output, 5 bits: register-file write index.
REQ-010 The block SHALL have port rd_value, output, DATA_W bits: register-file write data.
REQ-011 The block SHALL have port stall_cycles, output, 32 bits: contention counter (see Configuration).

Function
REQ-012 The block SHALL share the single register-file write port among three requesters using round-robin arbitration.
REQ-013 A transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-014 req_ready SHALL be one-hot or zero, and SHALL be 1 only for the single granted requester.
- req_ready SHALL be zero when req_valid is zero.
REQ-015 Grant search order SHALL be ptr, ptr+1, ptr+2 (mod 3), where ptr is a 2-bit round-robin pointer; the first valid requester in that order wins.
REQ-016 After a grant to requester i, ptr SHALL become (i+1) mod 3 on the next clock edge.
- With no valid requester, ptr SHALL hold its value.
- ptr SHALL never take the value 3.
REQ-017 A requester SHALL hold its valid, rd and data stable until accepted; the block need not tolerate withdrawal.
REQ-018 Output latency SHALL be exactly one cycle: a transfer accepted in cycle N SHALL drive wr_en/rd/rd_value in cycle N+1 from registers.
REQ-019 In any cycle with no transfer, the next cycle SHALL have wr_en=0, and rd and rd_value SHALL hold their previous values.
REQ-020 A transfer with rd=0 SHALL be accepted and SHALL advance ptr, but SHALL produce wr_en=0 the next cycle (x0 writes dropped).
REQ-021 The output stage SHALL never back-pressure, because the register file accepts one write every cycle; sustained throughput SHALL be one write per cycle.
REQ-022 With all three requesters continuously valid, grants SHALL rotate strictly; every requester SHALL wait at most 2 cycles.

Reset
REQ-023 On rst assertion, asynchronously: ptr=0, wr_en=0, rd=0, rd_value=0, stall_cycles=0.
REQ-024 While rst is high, req_ready SHALL be 0.
REQ-025 A transfer in flight (accepted the cycle before reset) SHALL be discarded; no write SHALL occur after reset asserts.
REQ-026 After rst deasserts, the first arbitration SHALL start from ptr=0.

Configuration
REQ-027 Macro WBARB_PERF_EN defined: stall_cycles SHALL increment by 1 each cycle in which at least one valid requester is not granted.
- The counter SHALL wrap from 0xFFFFFFFF to 0.
- Multiple stalled requesters in one cycle SHALL still count as one increment.
REQ-028 Macro WBARB_PERF_EN undefined: stall_cycles SHALL be constant 0, and no counter logic SHALL be present.

Verification
REQ-029 Single request: after reset, req_valid=3'b010, rd=5, data=0xDEADBEEF -> req_ready=3'b010 in the same cycle; next cycle wr_en=1, rd=5, rd_value=0xDEADBEEF; ptr=2.
REQ-030 Full contention: req_valid=3'b111 held for 6 cycles from ptr=0 -> grant order 0,1,2,0,1,2; wr_en=1 for 6 consecutive cycles starting one cycle later; stall_cycles=6 (PERF_EN).
REQ-031 x0 drop: requester 0 sends rd=0, data=0x1234 -> accepted; next cycle wr_en=0; ptr=1.
REQ-032 Rotation fairness: ptr=2 with req_valid=3'b011 -> requester 0 granted, then requester 1 granted; requester 2 never granted.
REQ-033 Reset mid-operation: rst asserted the cycle after a grant to rd=7 -> wr_en=0 immediately; outputs zero; ptr=0 after release.
REQ-034 Counter build check: without WBARB_PERF_EN, the REQ-030 stimulus -> stall_cycles=0 throughout.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter sharing one register-file write port among
// three writeback requesters (0=ALU, 1=LSU, 2=MDU).
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   req_valid[3]  per-requester writeback valid
//   req_rd[15]    per-requester destination index, requester i at [5i+4:5i]
//   req_data      per-requester write data, requester i at [DATA_W*i +: DATA_W]
//   req_ready[3]  combinational one-hot grant (zero when nothing is valid)
//   wr_en/rd/rd_value  registered register-file write, one cycle after accept
//   stall_cycles  cycles in which some valid requester was not granted
//
// Build option: define WBARB_PERF_EN to include the stall_cycles counter;
// without it stall_cycles is tied to zero and no counter exists.
module wb_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req_valid,
  input  logic [14:0]           req_rd,
  input  logic [3*DATA_W-1:0]   req_data,
  output logic [2:0]            req_ready,
  output logic                  wr_en,
  output logic [4:0]            rd,
  output logic [DATA_W-1:0]     rd_value,
  output logic [31:0]           stall_cycles
);

  localparam int NUM_REQ = 3;

  logic [NUM_REQ-1:0][4:0]        rd_arr;
  logic [NUM_REQ-1:0][DATA_W-1:0] data_arr;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign rd_arr[i]   = req_rd[5*i +: 5];
    assign data_arr[i] = req_data[DATA_W*i +: DATA_W];
  end

  logic [1:0] ptr;
  logic [1:0] cand;
  logic [1:0] gnt_idx;
  logic       gnt_any;
  logic [2:0] gnt_oh;

  // Walk ptr, ptr+1, ptr+2 (mod 3); first valid requester wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr;
    cand    = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
    end
  end

  assign gnt_oh    = gnt_any ? (3'b001 << gnt_idx) : 3'b000;
  // Reset is asynchronous, so the grant is masked combinationally as well.
  assign req_ready = rst ? 3'b000 : gnt_oh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= 2'd0;
      wr_en    <= 1'b0;
      rd       <= '0;
      rd_value <= '0;
    end else begin
      // x0 writes are accepted and rotate the pointer but never reach the RF.
      wr_en <= gnt_any && (rd_arr[gnt_idx] != 5'd0);
      if (gnt_any) begin
        ptr      <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
        rd       <= rd_arr[gnt_idx];
        rd_value <= data_arr[gnt_idx];
      end
    end
  end

`ifdef WBARB_PERF_EN
  // One increment per cycle no matter how many requesters are left waiting.
  logic stall_now;
  assign stall_now = |(req_valid & ~gnt_oh);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            stall_cycles <= '0;
    else if (stall_now) stall_cycles <= stall_cycles + 32'd1;
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized checks of wb_arbiter against a
// behavioural model (pointer as an integer, grants found by modulo search).
module tb_wb_arbiter;
  localparam int DATA_W = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [2:0]          req_valid = '0;
  logic [14:0]         req_rd = '0;
  logic [3*DATA_W-1:0] req_data = '0;
  logic [2:0]          req_ready;
  logic                wr_en;
  logic [4:0]          rd;
  logic [DATA_W-1:0]   rd_value;
  logic [31:0]         stall_cycles;

  wb_arbiter #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd),
    .req_data(req_data), .req_ready(req_ready), .wr_en(wr_en), .rd(rd),
    .rd_value(rd_value), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // reference model state
  int                m_ptr;
  logic              m_wr;
  logic [4:0]        m_rd;
  logic [DATA_W-1:0] m_val;
  logic [31:0]       m_stall;
  logic [2:0]        exp_gnt;
  logic [2:0]        obs_ready;

  function automatic void model_reset();
    m_ptr = 0; m_wr = 0; m_rd = '0; m_val = '0; m_stall = '0;
  endfunction

  function automatic logic [31:0] exp_stall();
`ifdef WBARB_PERF_EN
    return m_stall;
`else
    return 32'd0;
`endif
  endfunction

  // Called from a negedge: drive, sample ready, let one edge pass, update model.
  task automatic drive_cycle(input logic [2:0] v, input logic [14:0] rdv,
                             input logic [3*DATA_W-1:0] dv);
    int g;
    logic [4:0] r;
    req_valid = v; req_rd = rdv; req_data = dv;
    #1;
    obs_ready = req_ready;
    g = -1;
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (m_ptr + k) % 3;
      if (g < 0 && v[idx]) g = idx;
    end
    exp_gnt = (g >= 0) ? 3'(1 << g) : 3'b000;
    @(posedge clk);
    if ((v & ~exp_gnt) != 3'b000) m_stall = m_stall + 32'd1;
    if (g >= 0) begin
      r     = rdv[5*g +: 5];
      m_ptr = (g + 1) % 3;
      m_wr  = (r != 5'd0);
      m_rd  = r;
      m_val = dv[DATA_W*g +: DATA_W];
    end else begin
      m_wr = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 3'b111;
    #1;
    checks++; if (req_ready !== 3'b000) $display("FAIL reset_ready: got %b expected 000", req_ready); else passes++;
    checks++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b expected 0", wr_en); else passes++;
    checks++; if (rd !== 5'd0 || rd_value !== '0) $display("FAIL reset_out: got rd=%0d val=%h expected 0/0", rd, rd_value); else passes++;
    checks++; if (stall_cycles !== 32'd0) $display("FAIL reset_stall: got %0d expected 0", stall_cycles); else passes++;
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    drive_cycle(3'b010, 15'(5 << 5), {32'h0, 32'hDEADBEEF, 32'h0});
    checks++; if (obs_ready !== 3'b010) $display("FAIL single_ready: got %b expected 010", obs_ready); else passes++;
    checks++; if (wr_en !== 1'b1 || rd !== 5'd5 || rd_value !== 32'hDEADBEEF)
      $display("FAIL single_write: got en=%b rd=%0d val=%h expected 1/5/deadbeef", wr_en, rd, rd_value); else passes++;
    drive_cycle(3'b111, 15'h7FFF, '1);
    checks++; if (obs_ready !== exp_gnt || exp_gnt !== 3'b100) $display("FAIL single_ptr: got %b expected %b", obs_ready, exp_gnt); else passes++;
  endtask

  task automatic test_contention();
    int first_grant [6] = '{0, 1, 2, 0, 1, 2};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive_cycle(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC2, 32'hC1, 32'hC0});
      checks++; if (obs_ready !== 3'(1 << first_grant[c]) || obs_ready !== exp_gnt)
        $display("FAIL contention_grant%0d: got %b expected %b", c, obs_ready, 3'(1 << first_grant[c])); else passes++;
      checks++; if (wr_en !== 1'b1 || rd !== 5'(first_grant[c] + 1))
        $display("FAIL contention_write%0d: got en=%b rd=%0d expected 1/%0d", c, wr_en, rd, first_grant[c] + 1); else passes++;
    end
    checks++; if (stall_cycles !== exp_stall()) $display("FAIL contention_stall: got %0d expected %0d", stall_cycles, exp_stall()); else passes++;
    drive_cycle(3'b000, '0, '0);
    checks++; if (wr_en !== 1'b0 || rd !== 5'd3 || rd_value !== 32'hC2)
      $display("FAIL idle_hold: got en=%b rd=%0d val=%h expected 0/3/c2", wr_en, rd, rd_value); else passes++;
    checks++; if (stall_cycles !== exp_stall()) $display("FAIL idle_stall: got %0d expected %0d", stall_cycles, exp_stall()); else passes++;
  endtask

  task automatic test_x0();
    do_reset();
    drive_cycle(3'b001, 15'd0, {64'h0, 32'h1234});
    checks++; if (obs_ready !== 3'b001) $display("FAIL x0_ready: got %b expected 001", obs_ready); else passes++;
    checks++; if (wr_en !== 1'b0) $display("FAIL x0_wr_en: got %b expected 0", wr_en); else passes++;
    drive_cycle(3'b111, 15'h7FFF, '1);
    checks++; if (obs_ready !== 3'b010) $display("FAIL x0_ptr: got %b expected 010", obs_ready); else passes++;
  endtask

  task automatic test_fairness();
    do_reset();
    drive_cycle(3'b010, 15'(4 << 5), '0);  // leaves ptr at 2
    drive_cycle(3'b011, {5'd0, 5'd9, 5'd8}, {32'h0, 32'hB1, 32'hB0});
    checks++; if (obs_ready !== 3'b001) $display("FAIL fair_first: got %b expected 001", obs_ready); else passes++;
    drive_cycle(3'b011, {5'd0, 5'd9, 5'd8}, {32'h0, 32'hB1, 32'hB0});
    checks++; if (obs_ready !== 3'b010) $display("FAIL fair_second: got %b expected 010", obs_ready); else passes++;
    checks++; if (wr_en !== 1'b1 || rd !== 5'd9 || rd_value !== 32'hB1)
      $display("FAIL fair_write: got en=%b rd=%0d val=%h expected 1/9/b1", wr_en, rd, rd_value); else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_cycle(3'b001, 15'd7, {64'h0, 32'hA5A5});
    checks++; if (wr_en !== 1'b1 || rd !== 5'd7) $display("FAIL mid_pre: got en=%b rd=%0d expected 1/7", wr_en, rd); else passes++;
    req_valid = '0;
    rst = 1'b1;
    #1;
    checks++; if (wr_en !== 1'b0 || rd !== 5'd0 || rd_value !== '0 || stall_cycles !== 32'd0)
      $display("FAIL mid_reset: got en=%b rd=%0d val=%h st=%0d expected all zero", wr_en, rd, rd_value, stall_cycles); else passes++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive_cycle(3'b111, 15'h7FFF, '1);
    checks++; if (obs_ready !== 3'b001) $display("FAIL mid_ptr: got %b expected 001", obs_ready); else passes++;
  endtask

  task automatic test_random();
    logic [2:0]          v = '0;
    logic [14:0]         rv = '0;
    logic [3*DATA_W-1:0] dv = '0;
    int errs = 0;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      // A requester keeps its request stable until the model says it was granted.
      for (int i = 0; i < 3; i++) begin
        if (!v[i] || exp_gnt[i]) begin
          v[i] = ($urandom_range(0, 99) < 60);
          rv[5*i +: 5] = 5'($urandom_range(0, 31));
          dv[DATA_W*i +: DATA_W] = $urandom;
        end
      end
      exp_gnt = '0;
      drive_cycle(v, rv, dv);
      checks++; if (obs_ready !== exp_gnt) begin errs++; $display("FAIL rand_ready%0d: got %b expected %b", c, obs_ready, exp_gnt); end else passes++;
      checks++; if (wr_en !== m_wr) begin errs++; $display("FAIL rand_wr_en%0d: got %b expected %b", c, wr_en, m_wr); end else passes++;
      checks++; if (rd !== m_rd || rd_value !== m_val) begin errs++;
        $display("FAIL rand_out%0d: got rd=%0d val=%h expected %0d/%h", c, rd, rd_value, m_rd, m_val); end else passes++;
      checks++; if (stall_cycles !== exp_stall()) begin errs++;
        $display("FAIL rand_stall%0d: got %0d expected %0d", c, stall_cycles, exp_stall()); end else passes++;
      if (errs > 20) break;
    end
  endtask

  initial begin
    model_reset();
    exp_gnt = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_x0();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
